// File: rtl/round_pack_mult.sv
// rtl/round_pack_mult.sv - two-stage IEEE round/pack for multiplier results (optional ROUND_MODES_EN)

// Brent-Kung prefix adder; carry-in is folded into bit 0 generate
module bka_adder #(
  parameter int width = 24
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout
);

  localparam int hi_span = (width > 1) ? (1 << ($clog2(width) - 1)) : 1;

  logic [width-1:0] pp;
  logic [width-1:0] gg;
  logic [width-1:0] prop;

  // up-sweep builds power-of-two group terms, down-sweep fills the gaps
  always_comb begin
    prop  = a ^ b;
    pp    = prop;
    gg    = a & b;
    gg[0] = gg[0] | (prop[0] & cin);
    for (int d = 1; d < width; d = d * 2) begin
      for (int i = 2 * d - 1; i < width; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = hi_span; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < width; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
  end

  // sum bits from propagate and the prefix carry into each position
  always_comb begin
    sum    = prop;
    sum[0] = prop[0] ^ cin;
    for (int i = 1; i < width; i++) begin
      sum[i] = prop[i] ^ gg[i-1];
    end
    cout = gg[width-1];
  end

endmodule

module round_pack_mult #(
  parameter int sig_width = 23,
  parameter int ex_width  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          sign_in,
  input  logic                          zero_in,
  input  logic [sig_width-1:0]          mant_norm,
  input  logic [ex_width+1:0]           exp_norm,
  input  logic                          guard_bit,
  input  logic                          sticky_bit,
  input  logic [1:0]                    rnd_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sig_width+ex_width:0]   result,
  output logic                          flag_ovf,
  output logic                          flag_unf,
  output logic                          flag_inx
);

  localparam logic [1:0] mode_rne = 2'b00;
  localparam logic [1:0] mode_rtz = 2'b01;
  localparam logic [1:0] mode_rup = 2'b10;
  localparam logic [1:0] mode_rdn = 2'b11;

  localparam logic [ex_width+2:0] exp_ovf_lim = (ex_width+3)'((1 << ex_width) - 1);
  localparam logic [ex_width-1:0] exp_inf     = {ex_width{1'b1}};
  localparam logic [ex_width-1:0] exp_maxfin  = {{(ex_width-1){1'b1}}, 1'b0};

  logic [1:0] eff_mode;

`ifdef ROUND_MODES_EN
  assign eff_mode = rnd_mode;
`else
  logic unused_rnd_mode;
  assign unused_rnd_mode = ^rnd_mode;
  assign eff_mode = mode_rne;
`endif

  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_zero;
  logic [sig_width-1:0] s1_mant;
  logic [ex_width+1:0]  s1_exp;
  logic                 s1_inc;
  logic                 s1_inx;
  logic                 s1_ovf_inf;

  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & s1_adv;

  logic inc_c;
  logic ovf_inf_c;
  logic lost_bits;

  assign lost_bits = guard_bit | sticky_bit;

  // round increment and overflow-to-infinity choice from the selected mode
  always_comb begin
    inc_c     = 1'b0;
    ovf_inf_c = 1'b1;
    case (eff_mode)
      mode_rne: begin
        inc_c     = guard_bit & (sticky_bit | mant_norm[0]);
        ovf_inf_c = 1'b1;
      end
      mode_rtz: begin
        inc_c     = 1'b0;
        ovf_inf_c = 1'b0;
      end
      mode_rup: begin
        inc_c     = lost_bits & ~sign_in;
        ovf_inf_c = ~sign_in;
      end
      mode_rdn: begin
        inc_c     = lost_bits & sign_in;
        ovf_inf_c = sign_in;
      end
      default: begin
        inc_c     = 1'b0;
        ovf_inf_c = 1'b1;
      end
    endcase
  end

  // stage 1: capture the beat with its precomputed increment
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
      s1_inc     <= 1'b0;
      s1_inx     <= 1'b0;
      s1_ovf_inf <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_sign    <= sign_in;
        s1_zero    <= zero_in;
        s1_mant    <= mant_norm;
        s1_exp     <= exp_norm;
        s1_inc     <= inc_c;
        s1_inx     <= lost_bits;
        s1_ovf_inf <= ovf_inf_c;
      end
    end
  end

  logic [sig_width:0]  frac_sum;
  logic                add_cout_unused;
  logic                frac_carry;
  logic [ex_width+2:0] e_final;
  logic                e_ovf;
  logic                e_unf;

  bka_adder #(.width(sig_width + 1)) u_frac_add (
    .a    ({1'b0, s1_mant}),
    .b    ({{sig_width{1'b0}}, s1_inc}),
    .cin  (1'b0),
    .sum  (frac_sum),
    .cout (add_cout_unused)
  );

  assign frac_carry = frac_sum[sig_width];
  assign e_final    = {s1_exp[ex_width+1], s1_exp} + {{(ex_width+2){1'b0}}, frac_carry};
  assign e_ovf      = ~e_final[ex_width+2] & (e_final >= exp_ovf_lim);
  assign e_unf      = e_final[ex_width+2] | (e_final == '0);

  logic [sig_width+ex_width:0] res_c;
  logic                        ovf_c;
  logic                        unf_c;
  logic                        inx_c;

  // stage 2 packing: zero, overflow, underflow, then the normal rounded value
  always_comb begin
    res_c = {s1_sign, e_final[ex_width-1:0], frac_sum[sig_width-1:0]};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = s1_inx;
    if (s1_zero) begin
      res_c = {s1_sign, {(sig_width+ex_width){1'b0}}};
      inx_c = 1'b0;
    end else if (e_ovf) begin
      ovf_c = 1'b1;
      inx_c = 1'b1;
      if (s1_ovf_inf) begin
        res_c = {s1_sign, exp_inf, {sig_width{1'b0}}};
      end else begin
        res_c = {s1_sign, exp_maxfin, {sig_width{1'b1}}};
      end
    end else if (e_unf) begin
      res_c = {s1_sign, {(sig_width+ex_width){1'b0}}};
      unf_c = 1'b1;
      inx_c = 1'b1;
    end
  end

  // stage 2 output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inx  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_c;
        flag_ovf <= ovf_c;
        flag_unf <= unf_c;
        flag_inx <= inx_c;
      end
    end
  end

endmodule

// File: tb/tb_round_pack_mult.sv
// tb/tb_round_pack_mult.sv - directed self-checking bench for round_pack_mult

module tb_round_pack_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic        zero_in;
  logic [22:0] mant_norm;
  logic [9:0]  exp_norm;
  logic        guard_bit;
  logic        sticky_bit;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;

  int total = 0;
  int bad   = 0;

`ifdef ROUND_MODES_EN
  localparam bit modes_en = 1'b1;
`else
  localparam bit modes_en = 1'b0;
`endif

  round_pack_mult #(.sig_width(23), .ex_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .zero_in    (zero_in),
    .mant_norm  (mant_norm),
    .exp_norm   (exp_norm),
    .guard_bit  (guard_bit),
    .sticky_bit (sticky_bit),
    .rnd_mode   (rnd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_ovf   (flag_ovf),
    .flag_unf   (flag_unf),
    .flag_inx   (flag_inx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic set_beat(input logic sg, input logic z, input logic [22:0] m, input logic [9:0] e,
                          input logic g, input logic s, input logic [1:0] md);
    sign_in    = sg;
    zero_in    = z;
    mant_norm  = m;
    exp_norm   = e;
    guard_bit  = g;
    sticky_bit = s;
    rnd_mode   = md;
  endtask

  task automatic run_beat(input string tag, input logic sg, input logic z, input logic [22:0] m,
                          input logic [9:0] e, input logic g, input logic s, input logic [1:0] md,
                          input logic [31:0] want_res, input logic [2:0] want_flags);
    int lat;
    @(negedge clk);
    set_beat(sg, z, m, e, g, s, md);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ":rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":lat"}, lat, 2);
    check({tag, ":res"}, result, want_res);
    check({tag, ":flg"}, {flag_ovf, flag_unf, flag_inx}, want_flags);
  endtask

  initial begin
    int sent;
    int rcv;
    int ghosts;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_beat(0, 0, 23'h0, 10'h0, 0, 0, 2'b00);
    repeat (2) @(negedge clk);
    check("rst_ovalid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_ovf, flag_unf, flag_inx}, 0);
    check("rst_iready", in_ready, 1);
    rst = 1'b0;

    // flags ordered {ovf, unf, inx}
    run_beat("carry_up", 0, 0, 23'h7FFFFF, 10'd127, 1, 0, 2'b00, 32'h40000000, 3'b001);
    run_beat("tie_even", 0, 0, 23'h000000, 10'd127, 1, 0, 2'b00, 32'h3F800000, 3'b001);
    run_beat("tie_stky", 0, 0, 23'h000000, 10'd127, 1, 1, 2'b00, 32'h3F800001, 3'b001);
    run_beat("exact",    0, 0, 23'h123456, 10'd130, 0, 0, 2'b00, 32'h41123456, 3'b000);
    run_beat("tie_odd",  0, 0, 23'h000001, 10'd127, 1, 0, 2'b00, 32'h3F800002, 3'b001);
    run_beat("max_fin",  0, 0, 23'h7FFFFF, 10'd254, 0, 0, 2'b00, 32'h7F7FFFFF, 3'b000);
    run_beat("ovf_carry",0, 0, 23'h7FFFFF, 10'd254, 1, 0, 2'b00, 32'h7F800000, 3'b101);
    run_beat("ovf_rne",  0, 0, 23'h000000, 10'd255, 0, 0, 2'b00, 32'h7F800000, 3'b101);
    run_beat("exp_one",  0, 0, 23'h000000, 10'd1,   0, 0, 2'b00, 32'h00800000, 3'b000);
    run_beat("unf_zero", 1, 0, 23'h000000, 10'd0,   0, 0, 2'b00, 32'h80000000, 3'b011);
    run_beat("unf_neg",  1, 0, 23'h000000, 10'h3FF, 0, 0, 2'b00, 32'h80000000, 3'b011);
    run_beat("zero_in",  0, 1, 23'h7FFFFF, 10'd255, 1, 1, 2'b00, 32'h00000000, 3'b000);

    run_beat("ovf_rtz",  0, 0, 23'h000000, 10'd255, 0, 0, 2'b01,
             modes_en ? 32'h7F7FFFFF : 32'h7F800000, 3'b101);
    run_beat("ovf_rup_n",1, 0, 23'h000000, 10'd255, 0, 0, 2'b10,
             modes_en ? 32'hFF7FFFFF : 32'hFF800000, 3'b101);
    run_beat("rtz_stky", 0, 0, 23'h000000, 10'd127, 1, 1, 2'b01,
             modes_en ? 32'h3F800000 : 32'h3F800001, 3'b001);
    run_beat("rdn_neg",  1, 0, 23'h000000, 10'd127, 1, 0, 2'b11,
             modes_en ? 32'hBF800001 : 32'hBF800000, 3'b001);

    // backpressure: four beats offered while downstream stalls
    sent = 0;
    rcv  = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (sent < 4) begin
        set_beat(0, 0, 23'(sent + 1), 10'd127, 0, 0, 2'b00);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 3) check("bp_hold_mid", result, 32'h3F800001);
      if (in_valid && in_ready) sent++;
    end
    check("bp_accepted", sent, 2);
    check("bp_iready", in_ready, 0);
    check("bp_ovalid", out_valid, 1);
    check("bp_hold_end", result, 32'h3F800001);
    for (int c = 0; c < 20 && rcv < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 4) begin
        set_beat(0, 0, 23'(sent + 1), 10'd127, 0, 0, 2'b00);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check("bp_order", result, 32'h3F800001 + 32'(rcv));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_rcv", rcv, 4);
    check("bp_sent", sent, 4);

    // reset with two beats in flight
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (sent < 2) begin
        set_beat(0, 0, 23'(sent + 5), 10'd127, 0, 0, 2'b00);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) sent++;
    end
    check("rs_inflight", sent, 2);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_ovalid", out_valid, 0);
    check("rs_iready", in_ready, 1);
    check("rs_result", result, 0);
    out_ready = 1'b1;
    ghosts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    check("rs_ghosts", ghosts, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_pack_mult.md
ROUND_PACK_MULT -- requirements
Module: round_pack_mult

Interface
REQ-001 Parameter sig_width, default 23, stored mantissa width (fraction bits, hidden bit excluded).
REQ-002 Parameter ex_width, default 8, IEEE exponent field width; bias = 2^(ex_width-1)-1.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  block can accept a beat this cycle.
REQ-007 sign_in  in  1  product sign.
REQ-008 zero_in  in  1  product is exact zero; mantissa, exponent, guard and sticky are ignored.
REQ-009 mant_norm  in  sig_width  normalized fraction, hidden bit dropped.
REQ-010 exp_norm  in  ex_width+2  biased exponent, two's complement, upper 2 bits are overflow/negative headroom.
REQ-011 guard_bit, sticky_bit  in  1 each  first discarded bit, OR of remaining discarded bits.
REQ-012 rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf); sampled with the beat.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 result  out  sig_width+ex_width+1  packed {sign, exponent, fraction}.
REQ-016 flag_ovf, flag_unf, flag_inx  out  1 each  overflow, underflow, inexact for the beat on result.

Function
REQ-017 Two-stage pipeline: S1 registers the beat and computes the round increment; S2 adds it, fixes the exponent, detects range, packs; latency 2 cycles from acceptance to out_valid with no stalls.
REQ-018 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); beats are never dropped, duplicated or reordered.
REQ-019 S2 advances when ~out_valid|out_ready; S1 advances when ~s1_valid|S2 advances; in_ready = ~s1_valid|S2-advance (combinational from out_ready, no combinational path from in_valid).
REQ-020 result and flags hold stable while out_valid&~out_ready.
REQ-021 Increment inc: RNE guard&(sticky|mant_norm[0]); RTZ 0; RUP (guard|sticky)&~sign; RDN (guard|sticky)&sign.
REQ-022 Fraction sum uses the team's BKA adder at width sig_width+1; carry-out (all-ones fraction plus inc) yields fraction 0 and e_final = exp_norm+1, otherwise e_final = exp_norm.
REQ-023 Overflow when signed e_final >= 2^ex_width-1: flag_ovf=1, flag_inx=1; result is inf for RNE, for RUP when positive, and for RDN when negative; otherwise it is max finite (exponent 2^ex_width-2, fraction all ones), with the sign preserved.
REQ-024 Underflow when signed e_final <= 0 (no subnormals, flush to zero): result signed zero, flag_unf=1, flag_inx=1.
REQ-025 zero_in=1: result signed zero, all flags 0, no rounding.
REQ-026 Normal case: exponent field e_final[ex_width-1:0], fraction rounded sum, flag_inx = guard|sticky, flag_ovf = flag_unf = 0.

Reset
REQ-027 While rst is high on a clock edge: s1_valid, out_valid, result and all flags clear to 0 and in_ready reads 1 the next cycle.
REQ-028 Reset mid-operation discards all in-flight beats; none appear after reset.

Configuration
REQ-029 Macro ROUND_MODES_EN: when defined, all four modes follow rnd_mode; when undefined, rnd_mode is ignored, RNE is hard-wired, and overflow always yields signed inf.

Verification (sig_width=23, ex_width=8)
REQ-030 mant=0x7FFFFF, exp=127, g=1, s=0, RNE, sign=0 -> result 0x40000000, inx=1, out_valid exactly 2 cycles after acceptance.
REQ-031 mant=0, exp=127, g=1, s=0, RNE -> 0x3F800000 (tie to even), inx=1; same beat with s=1 -> 0x3F800001.
REQ-032 exp=255, RNE, sign=0 -> 0x7F800000, ovf=1, inx=1; with ROUND_MODES_EN and RTZ -> 0x7F7FFFFF; sign=1 with RUP -> 0xFF7FFFFF.
REQ-033 exp=0 or exp=0x3FF (-1), sign=1 -> 0x80000000, unf=1, inx=1; zero_in=1 -> 0x00000000, flags 0.
REQ-034 Hold out_ready=0 and offer 4 back-to-back beats -> exactly 2 are accepted, in_ready drops, the result stays stable; on release the results emerge in order and the remaining beats are accepted without loss.
REQ-035 Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle and neither beat is ever output.
